lc3b_line_write_buffer: RTL
===========================

// Module: lc3b_line_write_buffer
// PURPOSE
//  Parametrised write-back buffer between the L2 cache and physical memory.
//  Holds up to DEPTH evicted dirty lines and drains them to memory in the background.
//  Supports coalescing of repeat evictions and read-forwarding lookup, so the cache can refill without waiting for the drain.
//  Default widths match lc3b_line (128 b) and lc3b_word addressing (16 b).
// PARAMETERS
//  LINE_WIDTH   128  bits per cache line
//  ADDR_WIDTH   16   byte-address width
//  OFFSET_BITS  4    line-offset bits; tag = addr[ADDR_WIDTH-1:OFFSET_BITS]
//  DEPTH        4    entries, power of two, >= 2
// PORTS
//  clk         in   1           clock, all state updates on rising edge
//  rst         in   1           synchronous, active-high reset
//  wb_write    in   1           enqueue/coalesce request from cache (single-cycle qualifier)
//  wb_waddr    in   ADDR_WIDTH  line address of evicted line (offset bits ignored)
//  wb_wdata    in   LINE_WIDTH  evicted line data
//  wb_accept   out  1           comb: request this cycle is taken (enqueue or coalesce)
//  wb_full     out  1           registered: count == DEPTH
//  wb_empty    out  1           registered: count == 0
//  lk_addr     in   ADDR_WIDTH  lookup address from cache miss path
//  lk_hit      out  1           comb: some valid entry's tag matches lk_addr
//  lk_data     out  LINE_WIDTH  comb: data of newest matching entry; 0 when !lk_hit
//  hold        in   1           inhibit starting a new drain (cache owns memory port)
//  mem_write   out  1           registered write strobe to physical memory
//  mem_address out  ADDR_WIDTH  head tag with offset bits zero while mem_write; else 0
//  mem_wdata   out  LINE_WIDTH  head data while mem_write; else 0
//  mem_resp    in   1           memory completion, one cycle
// BEHAVIOUR
//  Storage: circular FIFO; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
//  Reset: count=0, pointers=0, all valid=0, FSM=IDLE, mem_write=0, wb_full=0, wb_empty=1.
//   lk_hit=0, mem_address/mem_wdata=0.
//  Write request (wb_write=1), evaluated against state at the clock edge:
//   - Coalesce: tag matches valid entry E, and E is not (head while FSM=WRITE).
//     -> E.data overwritten, count unchanged, wb_accept=1, accepted even if full.
//   - Else if count<DEPTH: write at tail, tail++, wb_accept=1.
//   - Else: wb_accept=0. Cache must hold request; no state change.
//   - Multiple tag matches: coalesce into newest non-excluded match.
//  Lookup: pure combinational, zero latency.
//   Newest matching entry wins (tail-1 backwards).
//   Reflects state before the current cycle's write.
//  Drain FSM:
//   IDLE:  if count>0 && !hold -> WRITE; mem_write=1 from the next cycle.
//   WRITE: mem_write=1, address/data held stable from head; hold ignored.
//          On mem_resp: pop head (valid=0, head++, count--) -> IDLE.
//          mem_write=0 the following cycle, so there is at least 1 IDLE cycle between lines.
//  mem_resp while IDLE is ignored.
//  Drain latency: first mem_write 1 cycle after entry is visible (count>0).
//  Same-cycle pop + enqueue: both apply; count unchanged.
//   wb_full uses registered count, so a full buffer refuses a new (non-coalescing) enqueue even in the pop cycle.
//  Reset mid-WRITE: entries discarded, mem_write=0 next cycle, late mem_resp ignored.
// TESTING
//  1. Reset, then enqueue A=0x1230 D0, hold=0.
//     -> mem_write=1 next cycle, mem_address=0x1230; mem_resp -> wb_empty=1, mem_write=0.
//  2. hold=1, enqueue 4 distinct lines -> wb_full=1; 5th write -> wb_accept=0, count stays 4.
//  3. hold=1, enqueue 0x2000 D1, then 0x2008 D2 -> coalesce.
//     count=1; lk_addr=0x2004 -> lk_hit=1, lk_data=D2.
//  4. Head 0x3000 in WRITE; write 0x3000 D3 -> new entry allocated.
//     Memory receives old data first, then D3; lookup returns D3 throughout.
//  5. Full, FSM=WRITE, mem_resp and wb_write (new tag) same cycle -> refused.
//     Retry next cycle accepted, count=4.
//  6. rst asserted while mem_write=1 -> next cycle mem_write=0, wb_empty=1.
//     Stray mem_resp causes no pop.

Source files
------------

// File: rtl/lc3b_line_write_buffer_if.sv
// lc3b_line_write_buffer_if: cache-side write/lookup and memory-side drain signals of the line write buffer
interface lc3b_line_write_buffer_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic                  wb_write;
  logic [ADDR_WIDTH-1:0] wb_waddr;
  logic [LINE_WIDTH-1:0] wb_wdata;
  logic                  wb_accept;
  logic                  wb_full;
  logic                  wb_empty;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic                  lk_hit;
  logic [LINE_WIDTH-1:0] lk_data;
  logic                  hold;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;
  modport master (
    output wb_write, wb_waddr, wb_wdata, lk_addr, hold, mem_resp,
    input  wb_accept, wb_full, wb_empty, lk_hit, lk_data, mem_write, mem_address, mem_wdata
  );
  modport slave (
    input  wb_write, wb_waddr, wb_wdata, lk_addr, hold, mem_resp,
    output wb_accept, wb_full, wb_empty, lk_hit, lk_data, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/lc3b_line_write_buffer.sv
// lc3b_line_write_buffer: FIFO of evicted dirty lines with coalescing, read forwarding and background drain
module lc3b_line_write_buffer #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH       = 4
) (
  input logic                    clk,
  input logic                    rst,
  lc3b_line_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = ADDR_WIDTH - OFFSET_BITS;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t                r_state, w_state_nxt;
  logic [TW-1:0]         r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_head, r_tail;
  logic [PW:0]           r_count, w_count_nxt;
  logic                  r_full, r_empty;
  logic [PW:0]           w_co, w_lk;
  logic                  w_room, w_enq, w_pop;
  // Walk oldest to newest so the last hit is the newest match
  function automatic logic [PW:0] find(input logic [TW-1:0] t, input logic excl_head);
    logic [PW:0]   r;
    logic [PW-1:0] k;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k = r_head + PW'(i);
      if (r_valid[k] && r_tag[k] == t && !(excl_head && k == r_head)) r = {1'b1, k};
    end
    return r;
  endfunction
  assign w_co        = find(bus.wb_waddr[ADDR_WIDTH-1:OFFSET_BITS], r_state == WRITE);
  assign w_lk        = find(bus.lk_addr[ADDR_WIDTH-1:OFFSET_BITS], 1'b0);
  assign w_room      = r_count != (PW+1)'(DEPTH);
  assign w_enq       = bus.wb_write && !w_co[PW] && w_room;
  assign w_pop       = r_state == WRITE && bus.mem_resp;
  assign w_count_nxt = r_count + (PW+1)'(w_enq) - (PW+1)'(w_pop);
  assign bus.wb_accept = bus.wb_write && (w_co[PW] || w_room);
  assign bus.wb_full   = r_full;
  assign bus.wb_empty  = r_empty;
  assign bus.lk_hit    = w_lk[PW];
  assign bus.lk_data   = w_lk[PW] ? r_data[w_lk[PW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (bus.wb_write && w_co[PW]) r_data[w_co[PW-1:0]] <= bus.wb_wdata;
      if (w_enq) begin
        r_tag[r_tail]   <= bus.wb_waddr[ADDR_WIDTH-1:OFFSET_BITS];
        r_data[r_tail]  <= bus.wb_wdata;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= w_count_nxt == (PW+1)'(DEPTH);
      r_empty <= w_count_nxt == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = (r_count != '0 && !bus.hold) ? WRITE : IDLE;
    else                 w_state_nxt = bus.mem_resp ? IDLE : WRITE;
  end
  always_comb begin
    bus.mem_write   = r_state == WRITE;
    bus.mem_address = (r_state == WRITE) ? {r_tag[r_head], {OFFSET_BITS{1'b0}}} : '0;
    bus.mem_wdata   = (r_state == WRITE) ? r_data[r_head] : '0;
  end
endmodule
